// File: rtl/img_pkg.sv
// Shared image-pipeline types and default geometry for the row-parallel filters.
package img_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int COL_DEFAULT   = 256;
    localparam int ROWS_DEFAULT  = 256;
    localparam int WIDTH_DEFAULT = 8;
    localparam int ROW_IDX_W     = idx_width(ROWS_DEFAULT);

    typedef logic [WIDTH_DEFAULT-1:0] pixel_t;

endpackage

// File: rtl/row_slot.sv
// One row buffer: lane-addressed pixel writes, a full flag and the row tag captured when filled.
// Set and clear never target the same slot in one cycle; the packer's pointer discipline guarantees it.
module row_slot
    import img_pkg::*;
#(
    parameter int COL   = COL_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int IDX_W = ROW_IDX_W,
    localparam int LANE_W = idx_width(COL)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [LANE_W-1:0]    wr_lane,
    input  logic [WIDTH-1:0]     wr_dat,
    input  logic                 set_full,
    input  logic                 clr_full,
    input  logic [IDX_W-1:0]     tag_in,
    output logic [COL*WIDTH-1:0] data,
    output logic                 full,
    output logic [IDX_W-1:0]     tag
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (wr_en) begin
            data[wr_lane*WIDTH +: WIDTH] <= wr_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            tag  <= '0;
        end else begin
            if (set_full) begin
                full <= 1'b1;
                tag  <= tag_in;
            end else if (clr_full) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pixel_row_packer.sv
// Packs a 1-pixel/cycle stream into COL-wide rows over two ping-pong slots; row_valid one cycle after a row's last pixel.
// pix_ready drops only when both slots hold rows the consumer has not taken; it never takes same-cycle credit.
module pixel_row_packer
    import img_pkg::*;
#(
    parameter int COL   = COL_DEFAULT,
    parameter int ROWS  = ROWS_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT,
    localparam int IDX_W  = idx_width(ROWS),
    localparam int LANE_W = idx_width(COL)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     pix_in,
    input  logic                 pix_valid,
    input  logic                 pix_sof,
    output logic                 pix_ready,
    output logic [COL*WIDTH-1:0] row_out,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic [IDX_W-1:0]     row_idx,
    output logic                 row_last,
    output logic                 err_sof
);

    logic                 ready_en;
    logic [LANE_W-1:0]    col_cnt;
    logic [LANE_W-1:0]    lane;
    logic [IDX_W-1:0]     row_cnt;
    logic [IDX_W-1:0]     cur_row;
    logic [IDX_W-1:0]     next_row;
    logic                 fill_ptr;
    logic                 rd_ptr;
    logic                 accept;
    logic                 sof_mis;
    logic                 complete;
    logic                 handshake;

    logic                 full0, full1;
    logic [COL*WIDTH-1:0] data0, data1;
    logic [IDX_W-1:0]     tag0, tag1;

    assign pix_ready = ready_en && !(full0 && full1);
    assign accept    = pix_valid && pix_ready;

    // A misaligned SOF restarts the partial row in place: the fill slot is
    // never full while accepting, so stale lanes get overwritten before it fills.
    assign sof_mis   = accept && pix_sof && (col_cnt != '0);
    assign lane      = sof_mis ? '0 : col_cnt;
    assign cur_row   = (accept && pix_sof) ? '0 : row_cnt;
    assign complete  = accept && (lane == LANE_W'(COL - 1));
    assign next_row  = (cur_row == IDX_W'(ROWS - 1)) ? '0 : cur_row + IDX_W'(1);

    assign row_valid = rd_ptr ? full1 : full0;
    assign row_out   = rd_ptr ? data1 : data0;
    assign row_idx   = rd_ptr ? tag1  : tag0;
    assign row_last  = row_valid && (row_idx == IDX_W'(ROWS - 1));
    assign handshake = row_valid && row_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
            err_sof  <= 1'b0;
            col_cnt  <= '0;
            row_cnt  <= '0;
            fill_ptr <= 1'b0;
            rd_ptr   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            err_sof  <= sof_mis;
            if (accept) begin
                col_cnt <= complete ? '0 : lane + LANE_W'(1);
                row_cnt <= complete ? next_row : cur_row;
            end
            if (complete) begin
                fill_ptr <= !fill_ptr;
            end
            if (handshake) begin
                rd_ptr <= !rd_ptr;
            end
        end
    end

    row_slot #(
        .COL   (COL),
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_slot0 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept && !fill_ptr),
        .wr_lane  (lane),
        .wr_dat   (pix_in),
        .set_full (complete && !fill_ptr),
        .clr_full (handshake && !rd_ptr),
        .tag_in   (cur_row),
        .data     (data0),
        .full     (full0),
        .tag      (tag0)
    );

    row_slot #(
        .COL   (COL),
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_slot1 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept && fill_ptr),
        .wr_lane  (lane),
        .wr_dat   (pix_in),
        .set_full (complete && fill_ptr),
        .clr_full (handshake && rd_ptr),
        .tag_in   (cur_row),
        .data     (data1),
        .full     (full1),
        .tag      (tag1)
    );

endmodule

// File: tb/tb_pixel_row_packer.sv
// Directed bench for pixel_row_packer with COL=4, ROWS=3, WIDTH=8 and an in-order row scoreboard.
module tb_pixel_row_packer;

    logic        clk;
    logic        rst;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_ready;
    logic [31:0] row_out;
    logic        row_valid;
    logic        row_ready;
    logic [1:0]  row_idx;
    logic        row_last;
    logic        err_sof;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] exp_row[$];
    logic [1:0]  exp_idx[$];
    logic        exp_last[$];

    logic        hold_vld = 1'b0;
    logic [31:0] hold_row;
    logic [1:0]  hold_idx;
    logic        hold_last;
    logic        rand_en = 1'b0;

    pixel_row_packer #(.COL(4), .ROWS(3), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_ready (pix_ready),
        .row_out   (row_out),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_idx   (row_idx),
        .row_last  (row_last),
        .err_sof   (err_sof)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", compared);
        $fatal(1, "watchdog");
    end

    always @(posedge clk) begin
        if (rand_en) begin
            #1;
            row_ready = ($urandom_range(0, 1) == 1);
        end
    end

    // Sampled at negedge: a row seen valid&&ready here is taken at the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                compared++;
                if (row_valid !== 1'b1 || row_out !== hold_row || row_idx !== hold_idx || row_last !== hold_last) begin
                    mismatched++;
                    $display("FAIL hold_stable: got vld=%b row=%h idx=%0d last=%b, need vld=1 row=%h idx=%0d last=%b",
                             row_valid, row_out, row_idx, row_last, hold_row, hold_idx, hold_last);
                end
            end
            if (row_valid && row_ready) begin
                compared++;
                if (exp_row.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_row: got row=%h idx=%0d, need no row", row_out, row_idx);
                end else begin
                    if (row_out !== exp_row[0] || row_idx !== exp_idx[0] || row_last !== exp_last[0]) begin
                        mismatched++;
                        $display("FAIL row_data: got row=%h idx=%0d last=%b, need row=%h idx=%0d last=%b",
                                 row_out, row_idx, row_last, exp_row[0], exp_idx[0], exp_last[0]);
                    end
                    void'(exp_row.pop_front());
                    void'(exp_idx.pop_front());
                    void'(exp_last.pop_front());
                end
            end
            hold_vld  = row_valid && !row_ready;
            hold_row  = row_out;
            hold_idx  = row_idx;
            hold_last = row_last;
        end
    end

    task automatic expect_row(input logic [31:0] r, input logic [1:0] idx, input logic last);
        exp_row.push_back(r);
        exp_idx.push_back(idx);
        exp_last.push_back(last);
    endtask

    task automatic push_pix(input logic [7:0] d, input logic sof, output int stalls);
        int n;
        n = 0;
        pix_in = d;
        pix_sof = sof;
        pix_valid = 1'b1;
        @(negedge clk);
        while (!pix_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        stalls = n;
        if (!pix_ready) begin
            compared++;
            mismatched++;
            $display("FAIL push_timeout: pix_ready=%b after %0d cycles, need 1", pix_ready, n);
        end else begin
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
        pix_sof = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        compared++;
        if (exp_row.size() != 0) begin
            mismatched++;
            $display("FAIL %s_drained: %0d rows still expected, need 0", name, exp_row.size());
            exp_row.delete();
            exp_idx.delete();
            exp_last.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        pix_in = '0;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        row_ready = 1'b0;
        wait_cycles(3);
        compared++;
        if (row_valid !== 1'b0 || row_out !== 32'h0 || row_idx !== 2'd0 || row_last !== 1'b0 ||
            err_sof !== 1'b0 || pix_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_values: got vld=%b row=%h idx=%0d last=%b err=%b rdy=%b, need all 0",
                     row_valid, row_out, row_idx, row_last, err_sof, pix_ready);
        end
        rst = 1'b0;
        #1;
        compared++;
        if (pix_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL ready_before_edge: got %b, need 0", pix_ready);
        end
        wait_cycles(1);
        compared++;
        if (pix_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL ready_after_release: got %b, need 1", pix_ready);
        end
    endtask

    task automatic test_single_row;
        int st;
        row_ready = 1'b1;
        expect_row(32'h13121110, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                compared++;
                if (row_valid !== 1'b0) begin
                    mismatched++;
                    $display("FAIL early_valid: got %b before last pixel, need 0", row_valid);
                end
            end
            push_pix(8'h10 + 8'(i), i == 0, st);
            compared++;
            if (st != 0) begin
                mismatched++;
                $display("FAIL single_ready: pixel %0d stalled %0d cycles, need 0", i, st);
            end
        end
        compared++;
        if (row_valid !== 1'b1 || row_out !== 32'h13121110 || row_idx !== 2'd0 || row_last !== 1'b0) begin
            mismatched++;
            $display("FAIL single_latency: got vld=%b row=%h idx=%0d last=%b, need vld=1 row=13121110 idx=0 last=0",
                     row_valid, row_out, row_idx, row_last);
        end
        wait_cycles(1);
        compared++;
        if (row_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL single_fall: got row_valid=%b after handshake, need 0", row_valid);
        end
        check_drained("single");
    endtask

    task automatic test_backpressure;
        int st;
        row_ready = 1'b0;
        expect_row(32'h23222120, 2'd0, 1'b0);
        expect_row(32'h27262524, 2'd1, 1'b0);
        expect_row(32'h2B2A2928, 2'd2, 1'b1);
        for (int i = 0; i < 8; i++) begin
            push_pix(8'h20 + 8'(i), i == 0, st);
            if (i == 6) begin
                compared++;
                if (pix_ready !== 1'b1) begin
                    mismatched++;
                    $display("FAIL bp_ready_7: got %b after 7th accept, need 1", pix_ready);
                end
            end
        end
        compared++;
        if (pix_ready !== 1'b0 || row_out !== 32'h23222120) begin
            mismatched++;
            $display("FAIL bp_full: got rdy=%b row=%h after 8th accept, need rdy=0 row=23222120", pix_ready, row_out);
        end
        wait_cycles(3);
        row_ready = 1'b1;
        wait_cycles(1);
        compared++;
        if (pix_ready !== 1'b1 || row_valid !== 1'b1 || row_idx !== 2'd1) begin
            mismatched++;
            $display("FAIL bp_release: got rdy=%b vld=%b idx=%0d, need rdy=1 vld=1 idx=1", pix_ready, row_valid, row_idx);
        end
        for (int i = 8; i < 12; i++) begin
            push_pix(8'h20 + 8'(i), 1'b0, st);
        end
        wait_cycles(2);
        check_drained("backpressure");
    endtask

    task automatic test_frame_wrap;
        int st;
        logic [31:0] r;
        row_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            r = {8'h33 + 8'(4*k), 8'h32 + 8'(4*k), 8'h31 + 8'(4*k), 8'h30 + 8'(4*k)};
            expect_row(r, 2'(k % 3), (k % 3) == 2);
        end
        for (int i = 0; i < 16; i++) begin
            push_pix(8'h30 + 8'(i), i == 0, st);
        end
        wait_cycles(2);
        check_drained("frame_wrap");
    endtask

    task automatic test_sof_misalign;
        int st;
        row_ready = 1'b1;
        expect_row(32'h04030201, 2'd0, 1'b0);
        push_pix(8'hAA, 1'b0, st);
        push_pix(8'hBB, 1'b0, st);
        compared++;
        if (err_sof !== 1'b0) begin
            mismatched++;
            $display("FAIL sof_err_pre: got %b, need 0", err_sof);
        end
        push_pix(8'h01, 1'b1, st);
        compared++;
        if (err_sof !== 1'b1) begin
            mismatched++;
            $display("FAIL sof_err_pulse: got %b, need 1", err_sof);
        end
        push_pix(8'h02, 1'b0, st);
        compared++;
        if (err_sof !== 1'b0) begin
            mismatched++;
            $display("FAIL sof_err_width: got %b one cycle later, need 0", err_sof);
        end
        push_pix(8'h03, 1'b0, st);
        push_pix(8'h04, 1'b0, st);
        wait_cycles(2);
        check_drained("sof_misalign");
    endtask

    task automatic test_reset_mid;
        int st;
        row_ready = 1'b0;
        expect_row(32'h53525150, 2'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            push_pix(8'h50 + 8'(i), i == 0, st);
        end
        compared++;
        if (row_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_pre_valid: got %b, need 1", row_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if (row_valid !== 1'b0 || pix_ready !== 1'b0 || row_out !== 32'h0) begin
            mismatched++;
            $display("FAIL mid_async: got vld=%b rdy=%b row=%h, need 0 0 00000000", row_valid, pix_ready, row_out);
        end
        exp_row.delete();
        exp_idx.delete();
        exp_last.delete();
        wait_cycles(2);
        rst = 1'b0;
        row_ready = 1'b1;
        wait_cycles(1);
        expect_row(32'h73727170, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push_pix(8'h70 + 8'(i), 1'b0, st);
        end
        compared++;
        if (row_valid !== 1'b1 || row_out !== 32'h73727170 || row_idx !== 2'd0) begin
            mismatched++;
            $display("FAIL mid_fresh: got vld=%b row=%h idx=%0d, need vld=1 row=73727170 idx=0", row_valid, row_out, row_idx);
        end
        wait_cycles(2);
        check_drained("reset_mid");
    endtask

    task automatic test_random_ready;
        int st;
        logic [7:0]  p;
        logic [31:0] r;
        for (int k = 0; k < 30; k++) begin
            for (int c = 0; c < 4; c++) begin
                p = 8'(5 * (4 * k + c) + 1);
                r[8*c +: 8] = p;
            end
            expect_row(r, 2'(k % 3), (k % 3) == 2);
        end
        rand_en = 1'b1;
        for (int i = 0; i < 120; i++) begin
            push_pix(8'(5 * i + 1), i == 0, st);
        end
        rand_en = 1'b0;
        wait_cycles(1);
        #1;
        row_ready = 1'b1;
        wait_cycles(4);
        check_drained("random_ready");
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_backpressure();
        test_frame_wrap();
        test_sof_misalign();
        test_reset_mid();
        test_random_ready();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
